// File: rtl/mul4_fitness_eval.sv
`default_nettype none
// ============================================================================
//  Module   : mul4_fitness_eval
//  Brief    : Bit-sliced fitness evaluator for 2x2-bit multiplier candidates.
//             Drives the exhaustive 16-lane stimulus, captures y3..y0 after
//             CAND_LAT extra cycles and scores matching bits (0..64).
//  Revision : 1.0 - initial release
// ============================================================================
module mul4_fitness_eval #(
  parameter int CAND_LAT = 0,   // extra candidate pipeline cycles before capture
  parameter int LANES    = 16   // lanes per word; only 16 is meaningful
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [6:0]       score_o,
  output logic             perfect_o,
  output logic [3:0]       err_mask_o,
  output logic             stim_valid_o,
  output logic [LANES-1:0] a1_o,
  output logic [LANES-1:0] a0_o,
  output logic [LANES-1:0] b1_o,
  output logic [LANES-1:0] b0_o,
  input  logic [LANES-1:0] y3_i,
  input  logic [LANES-1:0] y2_i,
  input  logic [LANES-1:0] y1_i,
  input  logic [LANES-1:0] y0_i
);

  // Lane i carries a = i[3:2], b = i[1:0]; these are the bit slices of that.
  localparam logic [LANES-1:0] c_a1 = 16'hFF00;
  localparam logic [LANES-1:0] c_a0 = 16'hF0F0;
  localparam logic [LANES-1:0] c_b1 = 16'hCCCC;
  localparam logic [LANES-1:0] c_b0 = 16'hAAAA;

  // Golden product bit slices for the lane encoding above.
  localparam logic [LANES-1:0] c_g0 = 16'hA0A0;
  localparam logic [LANES-1:0] c_g1 = 16'h6AC0;
  localparam logic [LANES-1:0] c_g2 = 16'h4C00;
  localparam logic [LANES-1:0] c_g3 = 16'h8000;

  // Counter must be at least one bit wide even for a combinational candidate.
  localparam int               CNT_W      = (CAND_LAT > 0) ? $clog2(CAND_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(CAND_LAT);
  localparam logic [6:0]       c_full     = 7'd64;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_SCORE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       word_q, word_d;
  logic [6:0]       acc_q, acc_d;
  logic [3:0]       emask_q, emask_d;
  logic [LANES-1:0] cap0_q, cap0_d, cap1_q, cap1_d, cap2_q, cap2_d, cap3_q, cap3_d;
  logic [LANES-1:0] a1_q, a1_d, a0_q, a0_d, b1_q, b1_d, b0_q, b0_d;
  logic             stim_valid_q, stim_valid_d;
  logic             done_q, done_d;
  logic [6:0]       score_q, score_d;
  logic             perfect_q, perfect_d;
  logic [3:0]       err_q, err_d;

  logic [LANES-1:0] w_cap;
  logic [LANES-1:0] w_gold;
  logic [LANES-1:0] w_diff;
  logic [4:0]       w_pop;
  logic [6:0]       w_acc_next;
  logic [3:0]       w_mask_next;

  // Select the captured word being scored this cycle and count its matching lanes.
  always_comb begin
    w_cap  = cap0_q;
    w_gold = c_g0;
    case (word_q)
      2'd0:    begin w_cap = cap0_q; w_gold = c_g0; end
      2'd1:    begin w_cap = cap1_q; w_gold = c_g1; end
      2'd2:    begin w_cap = cap2_q; w_gold = c_g2; end
      default: begin w_cap = cap3_q; w_gold = c_g3; end
    endcase
    w_diff = w_cap ^ w_gold;
    w_pop  = 5'd0;
    for (int i = 0; i < LANES; i++) begin
      w_pop = w_pop + {4'd0, ~w_diff[i]};
    end
    w_acc_next          = acc_q + {2'b00, w_pop};
    w_mask_next         = emask_q;
    w_mask_next[word_q] = emask_q[word_q] | (|w_diff);
  end

  // Next-state and datapath load decisions; every register holds by default.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    acc_d        = acc_q;
    emask_d      = emask_q;
    cap0_d       = cap0_q;
    cap1_d       = cap1_q;
    cap2_d       = cap2_q;
    cap3_d       = cap3_q;
    a1_d         = a1_q;
    a0_d         = a0_q;
    b1_d         = b1_q;
    b0_d         = b0_q;
    stim_valid_d = stim_valid_q;
    done_d       = 1'b0;
    score_d      = score_q;
    perfect_d    = perfect_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d      = S_DRIVE;
          a1_d         = c_a1;
          a0_d         = c_a0;
          b1_d         = c_b1;
          b0_d         = c_b0;
          stim_valid_d = 1'b1;
          cnt_d        = '0;
          word_d       = 2'd0;
          acc_d        = 7'd0;
          emask_d      = 4'd0;
        end
      end
      S_DRIVE: begin
        if (cnt_q == c_cnt_last) begin
          // Candidate output has settled: snapshot it and release the stimulus.
          cap0_d       = y0_i;
          cap1_d       = y1_i;
          cap2_d       = y2_i;
          cap3_d       = y3_i;
          a1_d         = '0;
          a0_d         = '0;
          b1_d         = '0;
          b0_d         = '0;
          stim_valid_d = 1'b0;
          state_d      = S_SCORE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SCORE: begin
        acc_d   = w_acc_next;
        emask_d = w_mask_next;
        word_d  = word_q + 2'd1;
        if (word_q == 2'd3) begin
          // Publish straight from the final sum so results land with done.
          state_d   = S_DONE;
          score_d   = w_acc_next;
          perfect_d = (w_acc_next == c_full);
          err_d     = w_mask_next;
          done_d    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      word_q       <= 2'd0;
      acc_q        <= 7'd0;
      emask_q      <= 4'd0;
      cap0_q       <= '0;
      cap1_q       <= '0;
      cap2_q       <= '0;
      cap3_q       <= '0;
      a1_q         <= '0;
      a0_q         <= '0;
      b1_q         <= '0;
      b0_q         <= '0;
      stim_valid_q <= 1'b0;
      done_q       <= 1'b0;
      score_q      <= 7'd0;
      perfect_q    <= 1'b0;
      err_q        <= 4'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      acc_q        <= acc_d;
      emask_q      <= emask_d;
      cap0_q       <= cap0_d;
      cap1_q       <= cap1_d;
      cap2_q       <= cap2_d;
      cap3_q       <= cap3_d;
      a1_q         <= a1_d;
      a0_q         <= a0_d;
      b1_q         <= b1_d;
      b0_q         <= b0_d;
      stim_valid_q <= stim_valid_d;
      done_q       <= done_d;
      score_q      <= score_d;
      perfect_q    <= perfect_d;
      err_q        <= err_d;
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;
  assign score_o      = score_q;
  assign perfect_o    = perfect_q;
  assign err_mask_o   = err_q;
  assign stim_valid_o = stim_valid_q;
  assign a1_o         = a1_q;
  assign a0_o         = a0_q;
  assign b1_o         = b1_q;
  assign b0_o         = b0_q;

endmodule
`default_nettype wire

// File: tb/tb_mul4_fitness_eval.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul4_fitness_eval
//  Brief    : Self-checking bench for mul4_fitness_eval with a combinational
//             candidate (CAND_LAT=0) and a two-register candidate (CAND_LAT=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mul4_fitness_eval;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start0, start2;
  logic [1:0] mode0, mode2;   // 0 golden, 1 all zeros, 2 all ones, 3 golden with y3=0

  logic        busy0, done0, perfect0, sv0;
  logic [6:0]  score0;
  logic [3:0]  em0;
  logic [15:0] a1_0, a0_0, b1_0, b0_0, y3_0, y2_0, y1_0, y0_0;

  logic        busy2, done2, perfect2, sv2;
  logic [6:0]  score2;
  logic [3:0]  em2;
  logic [15:0] a1_2, a0_2, b1_2, b0_2, y3_2, y2_2, y1_2, y0_2;

  logic [63:0] cand2_s1, cand2_s2;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [6:0] score;
    logic       perfect;
    logic [3:0] mask;
  } exp_t;

  exp_t q0[$];
  exp_t q2[$];

  mul4_fitness_eval #(.CAND_LAT(0), .LANES(16)) dut0 (
    .clk(clk), .rst(rst), .start_i(start0), .busy_o(busy0), .done_o(done0),
    .score_o(score0), .perfect_o(perfect0), .err_mask_o(em0), .stim_valid_o(sv0),
    .a1_o(a1_0), .a0_o(a0_0), .b1_o(b1_0), .b0_o(b0_0),
    .y3_i(y3_0), .y2_i(y2_0), .y1_i(y1_0), .y0_i(y0_0)
  );

  mul4_fitness_eval #(.CAND_LAT(2), .LANES(16)) dut2 (
    .clk(clk), .rst(rst), .start_i(start2), .busy_o(busy2), .done_o(done2),
    .score_o(score2), .perfect_o(perfect2), .err_mask_o(em2), .stim_valid_o(sv2),
    .a1_o(a1_2), .a0_o(a0_2), .b1_o(b1_2), .b0_o(b0_2),
    .y3_i(y3_2), .y2_i(y2_2), .y1_i(y1_2), .y0_i(y0_2)
  );

  // Candidate behaviour: multiply each lane's 2-bit operands, then apply the fault mode.
  function automatic logic [63:0] cand_f(input logic [1:0] mode, input logic [15:0] a1,
                                         input logic [15:0] a0, input logic [15:0] b1,
                                         input logic [15:0] b0);
    logic [63:0] y;
    logic [3:0]  p;
    y = '0;
    for (int i = 0; i < 16; i++) begin
      p = {2'b00, a1[i], a0[i]} * {2'b00, b1[i], b0[i]};
      case (mode)
        2'd0:    p = p;
        2'd1:    p = 4'h0;
        2'd2:    p = 4'hF;
        default: p[3] = 1'b0;
      endcase
      y[i]      = p[0];
      y[16 + i] = p[1];
      y[32 + i] = p[2];
      y[48 + i] = p[3];
    end
    return y;
  endfunction

  assign {y3_0, y2_0, y1_0, y0_0} = cand_f(mode0, a1_0, a0_0, b1_0, b0_0);

  // Two-register candidate for the CAND_LAT=2 instance.
  always @(posedge clk) begin
    cand2_s1 <= cand_f(mode2, a1_2, a0_2, b1_2, b0_2);
    cand2_s2 <= cand2_s1;
  end
  assign {y3_2, y2_2, y1_2, y0_2} = cand2_s2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon0
    exp_t e;
    if (done0 === 1'b1) begin
      chk("dut0_sb_entry", 64'(q0.size() > 0), 64'd1);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("dut0_score", 64'(score0), 64'(e.score));
        chk("dut0_perfect", 64'(perfect0), 64'(e.perfect));
        chk("dut0_err_mask", 64'(em0), 64'(e.mask));
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (done2 === 1'b1) begin
      chk("dut2_sb_entry", 64'(q2.size() > 0), 64'd1);
      if (q2.size() > 0) begin
        e = q2.pop_front();
        chk("dut2_score", 64'(score2), 64'(e.score));
        chk("dut2_perfect", 64'(perfect2), 64'(e.perfect));
        chk("dut2_err_mask", 64'(em2), 64'(e.mask));
      end
    end
  end

  // Advance negedges until done0 is seen, with a bounded budget.
  task automatic wait_done0(inout int n);
    while ((done0 !== 1'b1) && (n < 20)) begin
      @(negedge clk);
      n++;
    end
  endtask

  // One full run on the combinational-candidate instance.
  task automatic run0(input string tag, input logic [1:0] mode, input exp_t e);
    int n;
    mode0 = mode;
    @(negedge clk);
    q0.push_back(e);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk({tag, "_busy"}, 64'(busy0), 64'd1);
    chk({tag, "_a1_driven"}, 64'(a1_0), 64'hFF00);
    n = 0;
    wait_done0(n);
    chk({tag, "_latency"}, 64'(n), 64'd5);
    @(negedge clk);
    chk({tag, "_done_single"}, 64'(done0), 64'd0);
  endtask

  initial begin
    int n;
    int dones;
    rst    = 1'b1;
    start0 = 1'b0;
    start2 = 1'b0;
    mode0  = 2'd0;
    mode2  = 2'd0;

    // Asynchronous reset is effective before any clock edge.
    #2;
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_score", 64'(score0), 64'd0);
    chk("rst_perfect", 64'(perfect0), 64'd0);
    chk("rst_err_mask", 64'(em0), 64'd0);
    chk("rst_stim_valid", 64'(sv0), 64'd0);
    chk("rst_stim", 64'({a1_0, a0_0, b1_0, b0_0}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run0("golden", 2'd0, '{score: 7'd64, perfect: 1'b1, mask: 4'b0000});
    run0("zeros",  2'd1, '{score: 7'd50, perfect: 1'b0, mask: 4'b1111});
    run0("ones",   2'd2, '{score: 7'd14, perfect: 1'b0, mask: 4'b1111});

    // Two-register candidate with y3 stuck low.
    mode2 = 2'd3;
    @(negedge clk);
    q2.push_back('{score: 7'd63, perfect: 1'b0, mask: 4'b1000});
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("lat2_stim_all", {a1_2, a0_2, b1_2, b0_2}, 64'hFF00_F0F0_CCCC_AAAA);
    n = 0;
    while ((done2 !== 1'b1) && (n < 20)) begin
      if (n < 3) begin
        chk("lat2_a1_valid", 64'({sv2, a1_2}), 64'h1_FF00);
      end else if (n == 3) begin
        chk("lat2_a1_released", 64'({sv2, a1_2}), 64'h0_0000);
      end
      @(negedge clk);
      n++;
    end
    chk("lat2_latency", 64'(n), 64'd7);
    @(negedge clk);
    chk("lat2_done_single", 64'(done2), 64'd0);

    // Extra starts during DRIVE and SCORE must be ignored.
    mode0 = 2'd0;
    @(negedge clk);
    q0.push_back('{score: 7'd64, perfect: 1'b1, mask: 4'b0000});
    start0 = 1'b1;                 // sampled at edge k
    @(negedge clk);
    start0 = 1'b1;                 // sampled at k+1 (DRIVE)
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    start0 = 1'b1;                 // sampled at k+3 (SCORE)
    @(negedge clk);
    start0 = 1'b0;
    n = 3;
    wait_done0(n);
    chk("ignore_latency", 64'(n), 64'd5);
    // Start held through the DONE cycle: ignored there, accepted from IDLE.
    start0 = 1'b1;
    @(negedge clk);
    chk("ignore_done_single", 64'(done0), 64'd0);
    chk("ignore_idle_again", 64'(busy0), 64'd0);
    q0.push_back('{score: 7'd64, perfect: 1'b1, mask: 4'b0000});
    @(negedge clk);
    start0 = 1'b0;
    chk("restart_busy", 64'(busy0), 64'd1);
    n = 0;
    wait_done0(n);
    chk("restart_latency", 64'(n), 64'd5);
    @(negedge clk);

    // Asynchronous reset in the middle of SCORE abandons the run.
    mode0 = 2'd1;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_pre_busy", 64'(busy0), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy0), 64'd0);
    chk("midrst_outputs", 64'({done0, perfect0, sv0, em0, score0}), 64'd0);
    chk("midrst_stim", 64'({a1_0, a0_0, b1_0, b0_0}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done0 === 1'b1) dones++;
    end
    chk("midrst_no_done", 64'(dones), 64'd0);

    run0("post_rst", 2'd0, '{score: 7'd64, perfect: 1'b1, mask: 4'b0000});

    @(negedge clk);
    chk("sb0_drained", 64'(q0.size()), 64'd0);
    chk("sb2_drained", 64'(q2.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
